// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the SPI requester arbiter: FSM state encoding,
// default CS gap and timeout values, data byte width.
package spi_arb_pkg;

  localparam int BYTE_W       = 8;
  localparam int DEF_CS_SETUP = 2;
  localparam int DEF_CS_HOLD  = 2;
  localparam int DEF_TIMEOUT  = 1023;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4,
    S_HOLD  = 3'd5
  } state_t;

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
module spi_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int j_i;
    logic [IDX_W-1:0] j;
    j_i    = 0;
    j      = '0;
    gnt_oh = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j_i = int'(ptr) + k;
      if (j_i >= NUM_REQ) j_i = j_i - NUM_REQ;
      j = IDX_W'(j_i);
      if (!any && req[j]) begin
        any       = 1'b1;
        gnt_oh[j] = 1'b1;
        idx       = j;
      end
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin owner of one SPI shift engine with CS setup/hold sequencing.
// Define SPI_ARB_TIMEOUT_EN to add the eng_done watchdog and sticky timeout_err.
//
// state | meaning
// IDLE  | CS all high, arbitrate from rr pointer
// SETUP | owner's CS low, counting setup gap
// START | issue eng_start once engine is not busy
// WAIT  | byte shifting, waiting for eng_done
// RESP  | rsp_valid pulse; stays here while a locked owner has no next byte
// HOLD  | counting hold gap, then release CS and advance rr pointer
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int CS_SETUP = DEF_CS_SETUP,
  parameter int CS_HOLD  = DEF_CS_HOLD,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [BYTE_W*NUM_REQ-1:0] req_txdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [BYTE_W-1:0]         rsp_rxdata,
  output logic                      eng_start,
  output logic [BYTE_W-1:0]         eng_txdata,
  input  logic                      eng_busy,
  input  logic                      eng_done,
  input  logic [BYTE_W-1:0]         eng_rxdata,
  output logic [NUM_REQ-1:0]        cs_n,
  output logic                      timeout_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] SETUP_LD = 4'(CS_SETUP - 1);
  localparam logic [3:0] HOLD_LD  = 4'(CS_HOLD - 1);

  state_t             state;
  logic [3:0]         cnt;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_oh;
  logic               pick_any;
  logic [BYTE_W-1:0]  tx_sel;
  logic [IDX_W-1:0]   rr_next;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;
`else
  logic unused_tmo;
  assign unused_tmo  = (TIMEOUT != 0);
  assign timeout_err = 1'b0;
`endif

  spi_rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .gnt_oh(pick_oh),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    tx_sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (owner == IDX_W'(i)) tx_sel = req_txdata[i*BYTE_W +: BYTE_W];
  end

  assign rr_next = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      owner      <= '0;
      rr_ptr     <= '0;
      gnt        <= '0;
      rsp_valid  <= '0;
      rsp_rxdata <= '0;
      eng_start  <= 1'b0;
      eng_txdata <= '0;
      cs_n       <= '1;
`ifdef SPI_ARB_TIMEOUT_EN
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      eng_start <= 1'b0;
      rsp_valid <= '0;
      case (state)
        S_IDLE: begin
          if (pick_any) begin
            gnt   <= pick_oh;
            owner <= pick_idx;
            cnt   <= SETUP_LD;
            state <= S_SETUP;
          end
        end
        S_SETUP: begin
          cs_n <= ~gnt;
          if (cnt == 4'd0) state <= S_START;
          else             cnt   <= cnt - 4'd1;
        end
        S_START: begin
          if (!eng_busy) begin
            eng_start  <= 1'b1;
            eng_txdata <= tx_sel;
            state      <= S_WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
            tmo_cnt    <= TMO_W'(TIMEOUT - 1);
`endif
          end
        end
        S_WAIT: begin
          if (eng_done) begin
            rsp_rxdata <= eng_rxdata;
            rsp_valid  <= gnt;
            state      <= S_RESP;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          // Watchdog response skips RESP so a locked owner cannot keep the bus.
          else if (tmo_cnt == '0) begin
            timeout_err <= 1'b1;
            rsp_rxdata  <= 8'hFF;
            rsp_valid   <= gnt;
            cnt         <= HOLD_LD;
            state       <= S_HOLD;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
`endif
        end
        S_RESP: begin
          // First cycle only samples lock; the follow-on byte is taken from the next cycle.
          if (!req_lock[owner]) begin
            cnt   <= HOLD_LD;
            state <= S_HOLD;
          end else if (rsp_valid == '0 && req[owner]) begin
            state <= S_START;
          end
        end
        S_HOLD: begin
          if (cnt == 4'd0) begin
            cs_n   <= '1;
            gnt    <= '0;
            rr_ptr <= rr_next;
            state  <= S_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Scoreboarded bench for spi_req_arbiter with a behavioural SPI engine.
module tb_spi_req_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int TIMEOUT  = 16;
  localparam int ENG_LAT  = 8;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, req_lock, gnt, rsp_valid, cs_n;
  logic [31:0] req_txdata;
  logic [7:0]  rsp_rxdata, eng_txdata, eng_rxdata;
  logic        eng_start, eng_busy, eng_done, timeout_err;
  logic        busy_m, busy_force, eng_mute, burst_mon;
  logic [3:0]  prev_cs = 4'hF;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_start = 0;

  exp_t       start_q[$];
  exp_t       rsp_q[$];
  logic [7:0] rx_q[$];

  assign eng_busy = busy_m | busy_force;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_req_arbiter #(
    .NUM_REQ (NUM_REQ),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_lock   (req_lock),
    .req_txdata (req_txdata),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_rxdata (rsp_rxdata),
    .eng_start  (eng_start),
    .eng_txdata (eng_txdata),
    .eng_busy   (eng_busy),
    .eng_done   (eng_done),
    .eng_rxdata (eng_rxdata),
    .cs_n       (cs_n),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_xfer(input int idx, input logic [7:0] tx, input logic [7:0] rx);
    exp_t e;
    e.idx = idx; e.data = tx; start_q.push_back(e);
    e.data = rx; rsp_q.push_back(e);
    rx_q.push_back(rx);
  endtask

  task automatic wait_start(output int at);
    at = -1;
    for (int n = 0; n < 200 && at < 0; n++) begin
      @(negedge clk);
      if (eng_start === 1'b1) at = cyc;
    end
    if (at < 0) begin
      checks++; errors++;
      $display("FAIL wait_start: no eng_start within 200 cycles");
    end
  endtask

  task automatic wait_rsp(input int idx, output int at);
    at = -1;
    for (int n = 0; n < 200 && at < 0; n++) begin
      @(negedge clk);
      if (rsp_valid[idx[1:0]] === 1'b1) at = cyc;
    end
    if (at < 0) begin
      checks++; errors++;
      $display("FAIL wait_rsp%0d: no rsp_valid within 200 cycles", idx);
    end
  endtask

  task automatic wait_cs_high(input int idx, output int at);
    at = -1;
    for (int n = 0; n < 200 && at < 0; n++) begin
      @(negedge clk);
      if (cs_n[idx[1:0]] === 1'b1) at = cyc;
    end
    if (at < 0) begin
      checks++; errors++;
      $display("FAIL wait_cs%0d: cs_n never released within 200 cycles", idx);
    end
  endtask

  // Behavioural engine: done ENG_LAT cycles after the start pulse, data from rx_q.
  initial begin : engine
    int cnt;
    logic [7:0] cur;
    cnt = 0; cur = 8'h00;
    busy_m = 1'b0; eng_done = 1'b0; eng_rxdata = 8'h00;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (rst) begin
        busy_m = 1'b0; cnt = 0;
      end else if (cnt != 0) begin
        cnt--;
        if (cnt == 0) begin
          eng_done = 1'b1; eng_rxdata = cur; busy_m = 1'b0;
        end
      end else if (eng_start === 1'b1 && !eng_mute) begin
        busy_m = 1'b1;
        cnt = ENG_LAT - 1;
        cur = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      prev_cs = 4'hF;
    end else begin
      if (eng_start === 1'b1) begin
        n_start++;
        checks++;
        if (start_q.size() == 0) begin
          errors++;
          $display("FAIL start_unexpected: gnt=%b tx=%h with nothing expected", gnt, eng_txdata);
        end else begin
          e = start_q.pop_front();
          if (gnt !== 4'(1 << e.idx) || eng_txdata !== e.data) begin
            errors++;
            $display("FAIL start_xfer: got gnt=%b tx=%h expected gnt=%b tx=%h",
                     gnt, eng_txdata, 4'(1 << e.idx), e.data);
          end
        end
      end
      if (rsp_valid !== 4'h0) begin
        checks++;
        if (rsp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: rsp_valid=%b rx=%h with nothing expected", rsp_valid, rsp_rxdata);
        end else begin
          e = rsp_q.pop_front();
          if (rsp_valid !== 4'(1 << e.idx) || rsp_rxdata !== e.data) begin
            errors++;
            $display("FAIL rsp_xfer: got valid=%b rx=%h expected valid=%b rx=%h",
                     rsp_valid, rsp_rxdata, 4'(1 << e.idx), e.data);
          end
        end
      end
      checks++;
      if ($countones(~cs_n) > 1 || (cs_n !== prev_cs && cs_n !== 4'hF && prev_cs !== 4'hF)) begin
        errors++;
        $display("FAIL cs_gap: cs_n=%b previous=%b", cs_n, prev_cs);
      end
      if (burst_mon) chk("t3_cs2_held", 32'(cs_n[2]), 0);
      prev_cs = cs_n;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t0, ts, tr, tc, tcs, s1, s2, s3, r1, r2, r3, ns;
    rst = 1'b1; req = '0; req_lock = '0; req_txdata = '0;
    busy_force = 1'b0; eng_mute = 1'b0; burst_mon = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_cs_n", 32'(cs_n), 32'hF);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_eng_start", 32'(eng_start), 0);
    chk("rst_eng_txdata", 32'(eng_txdata), 0);
    chk("rst_rsp_rxdata", 32'(rsp_rxdata), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    rst = 1'b0;
    @(negedge clk);

    // All four requesting, no lock: round-robin 0,1,2,3,0
    req_txdata = {8'h13, 8'h12, 8'h11, 8'h10};
    expect_xfer(0, 8'h10, 8'hC0);
    expect_xfer(1, 8'h11, 8'hC1);
    expect_xfer(2, 8'h12, 8'hC2);
    expect_xfer(3, 8'h13, 8'hC3);
    expect_xfer(0, 8'h10, 8'hC4);
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_rsp(k % 4, tr);
      if (k == 4) req = 4'h0;
    end
    wait_cs_high(0, tc);

    // Single requester 1: latency of gnt, cs, start, rsp and CS release
    @(negedge clk);
    req_txdata[15:8] = 8'hA5;
    expect_xfer(1, 8'hA5, 8'h3C);
    req = 4'b0010;
    t0 = cyc;
    @(negedge clk);
    chk("t1_gnt", 32'(gnt), 32'b0010);
    chk("t1_cs_before", 32'(cs_n), 32'hF);
    @(negedge clk);
    chk("t1_cs_low", 32'(cs_n), 32'b1101);
    tcs = cyc;
    wait_start(ts);
    chk("t1_cs_to_start", ts - tcs, 2);
    chk("t1_req_to_start", ts - t0, 2 + CS_SETUP);
    wait_rsp(1, tr);
    req = 4'h0;
    chk("t1_start_to_rsp", tr - ts, ENG_LAT);
    wait_cs_high(1, tc);
    chk("t1_rsp_to_cs_high", tc - tr, CS_HOLD + 1);
    chk("t1_gnt_released", 32'(gnt), 0);

    // Locked 3-byte burst on requester 2 while requester 0 waits
    @(negedge clk);
    req_txdata[23:16] = 8'h21;
    req_txdata[7:0]   = 8'h5A;
    expect_xfer(2, 8'h21, 8'hD1);
    expect_xfer(2, 8'h22, 8'hD2);
    expect_xfer(2, 8'h23, 8'hD3);
    expect_xfer(0, 8'h5A, 8'hD4);
    req = 4'b0100; req_lock = 4'b0100;
    wait_start(s1);
    req[0] = 1'b1;
    burst_mon = 1'b1;
    wait_rsp(2, r1);
    req_txdata[23:16] = 8'h22;
    wait_start(s2);
    chk("t3_no_setup_gap1", s2 - r1, 3);
    wait_rsp(2, r2);
    req_txdata[23:16] = 8'h23;
    wait_start(s3);
    chk("t3_no_setup_gap2", s3 - r2, 3);
    req_lock[2] = 1'b0;
    wait_rsp(2, r3);
    req[2] = 1'b0;
    burst_mon = 1'b0;
    wait_rsp(0, tr);
    req[0] = 1'b0;
    chk("t3_req0_after_burst", 32'(tr > r3), 1);
    wait_cs_high(0, tc);

    // Engine busy when START is reached: start withheld, then a single pulse
    @(negedge clk);
    busy_force = 1'b1;
    req_txdata[15:8] = 8'h77;
    expect_xfer(1, 8'h77, 8'hE7);
    req = 4'b0010;
    ns = n_start;
    repeat (10) @(negedge clk);
    chk("t4_start_withheld", n_start, ns);
    busy_force = 1'b0;
    @(negedge clk);
    chk("t4_start_after_busy", 32'(eng_start), 1);
    @(negedge clk);
    chk("t4_single_pulse", 32'(eng_start), 0);
    wait_rsp(1, tr);
    req = 4'h0;
    wait_cs_high(1, tc);

    // Reset during WAIT: async release, then arbitration restarts at pointer 0
    @(negedge clk);
    req_txdata[31:24] = 8'h99;
    begin
      exp_t e;
      e.idx = 3; e.data = 8'h99; start_q.push_back(e);
      rx_q.push_back(8'h11);
    end
    req = 4'b1000;
    wait_start(ts);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_async_cs_n", 32'(cs_n), 32'hF);
    chk("t5_async_gnt", 32'(gnt), 0);
    chk("t5_async_rsp_valid", 32'(rsp_valid), 0);
    rx_q.delete();
    req = 4'b1010;
    req_txdata[15:8] = 8'h4B;
    expect_xfer(1, 8'h4B, 8'h66);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_rsp(1, tr);
    req = 4'h0;
    wait_cs_high(1, tc);

`ifdef SPI_ARB_TIMEOUT_EN
    // Silent engine: watchdog fires after TIMEOUT cycles in WAIT
    @(negedge clk);
    eng_mute = 1'b1;
    req_txdata[23:16] = 8'hC3;
    begin
      exp_t e;
      e.idx = 2; e.data = 8'hC3; start_q.push_back(e);
      e.data = 8'hFF; rsp_q.push_back(e);
    end
    req = 4'b0100;
    wait_start(ts);
    wait_rsp(2, tr);
    req = 4'h0;
    chk("t6_timeout_latency", tr - ts, TIMEOUT);
    chk("t6_timeout_err", 32'(timeout_err), 1);
    wait_cs_high(2, tc);
    chk("t6_rsp_to_cs_high", tc - tr, CS_HOLD);
    eng_mute = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_timeout_sticky", 32'(timeout_err), 1);
`else
    chk("timeout_err_tied_low", 32'(timeout_err), 0);
`endif

    repeat (3) @(negedge clk);
    chk("start_queue_drained", start_q.size(), 0);
    chk("rsp_queue_drained", rsp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
